// File: rtl/rdy_vld_pkg.sv
// Shared types and helpers for ready/valid arbitration blocks.
package rdy_vld_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest set request at or after ptr, with wrap.
module rr_pick
  import rdy_vld_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDW-1:0]     gnt_id,
  output logic               any
);

  logic [NUM_REQ-1:0]   w_mask;
  logic [2*NUM_REQ-1:0] w_dbl;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_mask = '0;
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) w_mask[i] = (i >= int'(ptr));
    // Low half holds requests at/after ptr, high half the wrapped copy.
    w_dbl = {req, req & w_mask};
    for (int j = 2 * NUM_REQ - 1; j >= 0; j--)
      if (w_dbl[j]) gnt_id = IDW'(j % NUM_REQ);
    any    = |req;
    gnt_oh = any ? (NUM_REQ'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/rr_pkt_arbiter.sv
// Packet-aware round-robin arbiter feeding one registered ready/valid output slice.
module rr_pkt_arbiter
  import rdy_vld_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DWIDTH  = 32,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              vld_in,
  input  logic [NUM_REQ-1:0][DWIDTH-1:0]  din,
  input  logic [NUM_REQ-1:0]              last_in,
  output logic [NUM_REQ-1:0]              rdy_out,
  output logic                            vld_out,
  output logic [DWIDTH-1:0]               dout,
  output logic                            last_out,
  output logic [IDW-1:0]                  src_id,
  input  logic                            rdy_in
);

  arb_state_e         r_state, w_state_nxt;
  logic [IDW-1:0]     r_ptr, r_lock_id, r_src;
  logic [IDW-1:0]     w_pick_id, w_winner, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic               w_pick_any, w_locked, w_slot_free, w_acc, w_win_last;
  logic               r_vld, r_last;
  logic [DWIDTH-1:0]  r_dout;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (vld_in),
    .ptr    (r_ptr),
    .gnt_oh (w_pick_oh),
    .gnt_id (w_pick_id),
    .any    (w_pick_any)
  );

  always_comb begin
    w_locked    = (r_state == ARB_LOCKED);
    w_slot_free = ~r_vld | rdy_in;
    w_winner    = w_locked ? r_lock_id : w_pick_id;
    w_win_last  = last_in[w_winner];
    w_acc       = w_slot_free & (w_locked ? vld_in[r_lock_id] : w_pick_any);
    w_ptr_nxt   = (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    // A locked owner sees ready even while it idles between beats.
    rdy_out     = '0;
    if (w_slot_free) rdy_out = w_locked ? (NUM_REQ'(1) << r_lock_id) : w_pick_oh;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:   if (w_acc && !w_win_last) w_state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (w_acc &&  w_win_last) w_state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_lock_id <= '0;
      r_vld     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc && !w_locked && !w_win_last) r_lock_id <= w_winner;
      if (w_acc && w_win_last) r_ptr <= w_ptr_nxt;
      if (w_acc)       r_vld <= 1'b1;
      else if (rdy_in) r_vld <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; they are qualified by r_vld, which is reset.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_dout <= din[w_winner];
      r_last <= w_win_last;
      r_src  <= w_winner;
    end
  end

  assign vld_out  = r_vld;
  assign dout     = r_dout;
  assign last_out = r_last;
  assign src_id   = r_src;

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Directed and soak bench for rr_pkt_arbiter (4-input main instance, 3-input wrap instance).
module tb_rr_pkt_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       vld_in, last_in, rdy_out;
  logic [3:0][31:0] din;
  logic             vld_out, last_out, rdy_in;
  logic [31:0]      dout;
  logic [1:0]       src_id;

  logic [2:0]       vld3, last3, rdy3;
  logic [2:0][7:0]  din3;
  logic             vldo3, lasto3, rdyin3;
  logic [7:0]       dout3;
  logic [1:0]       src3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0]  src;
    logic        last;
    logic [31:0] data;
  } beat_t;

  rr_pkt_arbiter #(.NUM_REQ(4), .DWIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .din(din), .last_in(last_in),
    .rdy_out(rdy_out), .vld_out(vld_out), .dout(dout), .last_out(last_out),
    .src_id(src_id), .rdy_in(rdy_in)
  );

  rr_pkt_arbiter #(.NUM_REQ(3), .DWIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .vld_in(vld3), .din(din3), .last_in(last3),
    .rdy_out(rdy3), .vld_out(vldo3), .dout(dout3), .last_out(lasto3),
    .src_id(src3), .rdy_in(rdyin3)
  );

  function automatic logic [31:0] beat_val(input int i, input int b);
    return 32'hD000_0000 | (32'(i) << 8) | 32'(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld_in = '0; last_in = '0; din = '0; rdy_in = 1'b1;
    vld3 = '0; last3 = '0; din3 = '0; rdyin3 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (vld_out !== 1'b0) begin n_errors++; $display("FAIL reset_vld: got %b want 0", vld_out); end
    @(negedge clk);
    n_checks++;
    if (rdy_out !== 4'b0000) begin n_errors++; $display("FAIL reset_rdy: got %b want 0000", rdy_out); end
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    vld_in = 4'b1111; last_in = 4'b1111; rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = beat_val(i, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (rdy_out !== (4'b0001 << (k % 4))) begin
        n_errors++; $display("FAIL fair_rdy[%0d]: got %b want %b", k, rdy_out, 4'b0001 << (k % 4));
      end
      tick();
      n_checks++;
      if (vld_out !== 1'b1 || src_id !== 2'(k % 4) || dout !== beat_val(k % 4, 0)) begin
        n_errors++; $display("FAIL fair_out[%0d]: got vld=%b src=%0d dout=%h want vld=1 src=%0d dout=%h",
                             k, vld_out, src_id, dout, k % 4, beat_val(k % 4, 0));
      end
    end
  endtask

  task automatic test_packet_lock();
    // Per cycle: vld_in, req0 last, req0 beat, expected rdy_out, then expected output after the edge.
    logic [3:0] v_tab  [5] = '{4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0010};
    logic       l_tab  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int         b_tab  [5] = '{0, 0, 1, 2, 0};
    logic [3:0] r_tab  [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic       ov_tab [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] os_tab [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic       ol_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] od_tab [5];
    od_tab = '{beat_val(0, 0), 32'h0, beat_val(0, 1), beat_val(0, 2), beat_val(1, 0)};
    do_reset();
    din[1] = beat_val(1, 0); last_in[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vld_in = v_tab[c]; last_in[0] = l_tab[c]; din[0] = beat_val(0, b_tab[c]);
      @(negedge clk);
      n_checks++;
      if (rdy_out !== r_tab[c]) begin
        n_errors++; $display("FAIL lock_rdy[%0d]: got %b want %b", c, rdy_out, r_tab[c]);
      end
      tick();
      n_checks++;
      if (vld_out !== ov_tab[c] ||
          (ov_tab[c] && (src_id !== os_tab[c] || last_out !== ol_tab[c] || dout !== od_tab[c]))) begin
        n_errors++; $display("FAIL lock_out[%0d]: got vld=%b src=%0d last=%b dout=%h want vld=%b src=%0d last=%b dout=%h",
                             c, vld_out, src_id, last_out, dout, ov_tab[c], os_tab[c], ol_tab[c], od_tab[c]);
      end
    end
    vld_in = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    vld_in = 4'b0100; last_in = 4'b0100; din[2] = beat_val(2, 0); rdy_in = 1'b1;
    tick();
    din[2] = beat_val(2, 1); rdy_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (rdy_out !== 4'b0000) begin n_errors++; $display("FAIL bp_rdy[%0d]: got %b want 0000", k, rdy_out); end
      tick();
      n_checks++;
      if (vld_out !== 1'b1 || src_id !== 2'd2 || last_out !== 1'b1 || dout !== beat_val(2, 0)) begin
        n_errors++; $display("FAIL bp_hold[%0d]: got vld=%b src=%0d last=%b dout=%h want vld=1 src=2 last=1 dout=%h",
                             k, vld_out, src_id, last_out, dout, beat_val(2, 0));
      end
    end
    rdy_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rdy_out !== 4'b0100) begin n_errors++; $display("FAIL bp_release_rdy: got %b want 0100", rdy_out); end
    tick();
    vld_in = '0;
    n_checks++;
    if (vld_out !== 1'b1 || dout !== beat_val(2, 1)) begin
      n_errors++; $display("FAIL bp_next: got vld=%b dout=%h want vld=1 dout=%h", vld_out, dout, beat_val(2, 1));
    end
    tick();
    n_checks++;
    if (vld_out !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got vld=%b want 0", vld_out); end
  endtask

  task automatic test_wrap3();
    do_reset();
    vld3 = 3'b101; last3 = 3'b111; rdyin3 = 1'b1;
    din3[0] = 8'hA0; din3[2] = 8'hA2;
    for (int k = 0; k < 6; k++) begin
      int exp_id;
      exp_id = (k % 2 == 0) ? 0 : 2;
      @(negedge clk);
      n_checks++;
      if (rdy3 !== (3'b001 << exp_id)) begin
        n_errors++; $display("FAIL wrap_rdy[%0d]: got %b want %b", k, rdy3, 3'b001 << exp_id);
      end
      tick();
      n_checks++;
      if (vldo3 !== 1'b1 || src3 !== 2'(exp_id) || lasto3 !== 1'b1 || dout3 !== (8'hA0 | 8'(exp_id))) begin
        n_errors++; $display("FAIL wrap_out[%0d]: got vld=%b src=%0d last=%b dout=%h want src=%0d",
                             k, vldo3, src3, lasto3, dout3, exp_id);
      end
    end
    vld3 = '0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    // Single beat from req2 moves the pointer to 3 before the interrupted packet.
    vld_in = 4'b0100; last_in = 4'b0100; din[2] = beat_val(2, 0);
    tick();
    vld_in = 4'b0010; last_in = 4'b0000;
    for (int b = 0; b < 2; b++) begin
      din[1] = beat_val(1, b);
      @(negedge clk);
      n_checks++;
      if (rdy_out !== 4'b0010) begin n_errors++; $display("FAIL rstmid_rdy[%0d]: got %b want 0010", b, rdy_out); end
      tick();
    end
    din[1] = beat_val(1, 2); rst = 1'b1;
    tick();
    rst = 1'b0; vld_in = '0;
    n_checks++;
    if (vld_out !== 1'b0) begin n_errors++; $display("FAIL rstmid_vld: got %b want 0", vld_out); end
    @(negedge clk);
    n_checks++;
    if (rdy_out !== 4'b0000) begin n_errors++; $display("FAIL rstmid_unlock: got %b want 0000", rdy_out); end
    tick();
    vld_in = 4'b1010; last_in = 4'b1111; din[1] = beat_val(1, 9); din[3] = beat_val(3, 9);
    @(negedge clk);
    n_checks++;
    if (rdy_out !== 4'b0010) begin n_errors++; $display("FAIL rstmid_ptr: got %b want 0010", rdy_out); end
    tick();
    vld_in = '0;
    n_checks++;
    if (vld_out !== 1'b1 || src_id !== 2'd1 || dout !== beat_val(1, 9)) begin
      n_errors++; $display("FAIL rstmid_first: got vld=%b src=%0d dout=%h want vld=1 src=1 dout=%h",
                           vld_out, src_id, dout, beat_val(1, 9));
    end
    tick();
  endtask

  task automatic test_soak();
    beat_t      exp_q[$];
    beat_t      b;
    logic [3:0] acc_m;
    int         seq [4];
    bit         in_pkt;
    int         pkt_src, idx;
    do_reset();
    acc_m = '0; in_pkt = 1'b0; pkt_src = 0;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_m[i]) vld_in[i] = 1'b0;
        if (!vld_in[i] && $urandom_range(0, 2) == 0) begin
          vld_in[i]  = 1'b1;
          din[i]     = (32'(i) << 24) | 32'(seq[i]);
          last_in[i] = ($urandom_range(0, 2) == 0);
          seq[i]++;
        end
      end
      rdy_in = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_checks++;
      if (!$onehot0(rdy_out)) begin n_errors++; $display("FAIL soak_onehot[%0d]: got %b", cyc, rdy_out); end
      if (vld_out && rdy_in) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL soak_extra[%0d]: got src=%0d dout=%h want no beat", cyc, src_id, dout);
        end else begin
          b = exp_q.pop_front();
          if ({src_id, last_out, dout} !== b) begin
            n_errors++; $display("FAIL soak_beat[%0d]: got src=%0d last=%b dout=%h want src=%0d last=%b dout=%h",
                                 cyc, src_id, last_out, dout, b.src, b.last, b.data);
          end
        end
      end
      acc_m = vld_in & rdy_out;
      if (acc_m != '0) begin
        idx = 0;
        for (int i = 3; i >= 0; i--) if (acc_m[i]) idx = i;
        n_checks++;
        if (in_pkt && idx != pkt_src) begin
          n_errors++; $display("FAIL soak_interleave[%0d]: got src=%0d want src=%0d", cyc, idx, pkt_src);
        end
        exp_q.push_back('{src: 2'(idx), last: last_in[idx], data: din[idx]});
        in_pkt  = !last_in[idx];
        pkt_src = idx;
      end
      tick();
    end
    vld_in = '0; rdy_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (vld_out) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL soak_drain_extra: got src=%0d dout=%h want no beat", src_id, dout);
        end else begin
          b = exp_q.pop_front();
          if ({src_id, last_out, dout} !== b) begin
            n_errors++; $display("FAIL soak_drain_beat: got dout=%h want dout=%h", dout, b.data);
          end
        end
      end
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL soak_lost: got %0d beats left want 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; vld_in = '0; last_in = '0; din = '0; rdy_in = 1'b1;
    vld3 = '0; last3 = '0; din3 = '0; rdyin3 = 1'b1;
    test_reset();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_wrap3();
    test_reset_mid_packet();
    test_soak();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
